// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF subframe decoder.
// Preamble cell patterns are written oldest cell first (bit 7 = oldest);
// each one also matches in its complemented polarity.
package spdif_pkg;

    localparam int unsigned CELLS_PER_BIT = 2;
    localparam int unsigned SAMPLE_WIDTH  = 24;
    localparam int unsigned WIN_WIDTH     = 8;

    // Subframe bit positions
    localparam int unsigned AUX_LSB   = 4;
    localparam int unsigned AUDIO_MSB = 27;
    localparam int unsigned BIT_V     = 28;
    localparam int unsigned BIT_U     = 29;
    localparam int unsigned BIT_C     = 30;
    localparam int unsigned BIT_P     = 31;

    // Bits 4..31 follow the preamble, each carried by two cells
    localparam int unsigned SF_BITS    = BIT_P - AUX_LSB + 1;
    localparam int unsigned DATA_CELLS = SF_BITS * CELLS_PER_BIT;
    localparam int unsigned CNT_W      = $clog2(DATA_CELLS);
    localparam int unsigned PRE_CNT_W  = $clog2(WIN_WIDTH);

    localparam logic [WIN_WIDTH-1:0] PRE_B = 8'b1110_1000;
    localparam logic [WIN_WIDTH-1:0] PRE_M = 8'b1110_0010;
    localparam logic [WIN_WIDTH-1:0] PRE_W = 8'b1110_0100;

    // Preamble type codes
    localparam logic [1:0] PT_B = 2'd0;
    localparam logic [1:0] PT_M = 2'd1;
    localparam logic [1:0] PT_W = 2'd2;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        PRE  = 2'd2
    } state_t;

endpackage

// File: rtl/spdif_preamble_match.sv
// Combinational B/M/W preamble detector over an 8-cell window, both polarities.
// Ports:
//   cell_win  8-cell window, bit 0 = newest cell
//   match     1 when the window holds a preamble
//   pre_type  PT_B / PT_M / PT_W (PT_B when no match)
module spdif_preamble_match
    import spdif_pkg::*;
(
    input  logic [WIN_WIDTH-1:0] cell_win,
    output logic                 match,
    output logic [1:0]           pre_type
);

    always_comb begin
        match    = 1'b0;
        pre_type = PT_B;
        if (cell_win == PRE_B || cell_win == ~PRE_B) begin
            match    = 1'b1;
            pre_type = PT_B;
        end else if (cell_win == PRE_M || cell_win == ~PRE_M) begin
            match    = 1'b1;
            pre_type = PT_M;
        end else if (cell_win == PRE_W || cell_win == ~PRE_W) begin
            match    = 1'b1;
            pre_type = PT_W;
        end
    end

endmodule

// File: rtl/spdif_subframe_decoder.sv
// S/PDIF subframe decoder: biphase-mark decode of half-bit cells from the
// clock-recovery stage, preamble sync, and per-subframe sample/status output.
// Build option: SPDIF_PARITY_DROP_EN suppresses sample_valid for subframes
// with a parity error (fields and lock still update).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   tos_ce         one-cycle strobe per half-bit cell
//   tos_data       cell value, valid with tos_ce
//   sample_valid   one-cycle pulse per completed subframe
//   sample         audio word, bit 0 = subframe bit 4
//   chan           1 = channel B (W preamble)
//   block_start    1 = subframe began with B preamble
//   v_bit, u_bit, c_bit  subframe bits 28, 29, 30
//   parity_err     odd parity over bits 4..31
//   locked         valid subframe decoded and sync held
module spdif_subframe_decoder
    import spdif_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tos_ce,
    input  logic                    tos_data,
    output logic                    sample_valid,
    output logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    chan,
    output logic                    block_start,
    output logic                    v_bit,
    output logic                    u_bit,
    output logic                    c_bit,
    output logic                    parity_err,
    output logic                    locked
);

    state_t                 state, state_next;
    logic [WIN_WIDTH-1:0]   cell_win;
    logic [CNT_W-1:0]       cell_cnt;
    logic [PRE_CNT_W-1:0]   pre_cnt;
    logic                   prev_cell;
    logic [1:0]             pre_type;
    logic [SF_BITS-1:0]     sf;          // sf[0] = subframe bit 4

    logic [WIN_WIDTH-1:0]   win_next_c;
    logic                   pre_match_c;
    logic [1:0]             pre_type_c;
    logic                   bit_c;
    logic [SF_BITS-1:0]     sf_next_c;
    logic                   parity_c;
    logic                   start_data_c;
    logic                   sf_done_c;
    logic                   lose_lock_c;

    // Window including the cell arriving this strobe
    assign win_next_c = {cell_win[WIN_WIDTH-2:0], tos_data};
    assign bit_c      = prev_cell ^ tos_data;
    assign sf_next_c  = {bit_c, sf[SF_BITS-1:1]};
    assign parity_c   = ^sf_next_c;

    spdif_preamble_match u_preamble_match (
        .cell_win (win_next_c),
        .match    (pre_match_c),
        .pre_type (pre_type_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    // Next-state and control decode
    always_comb begin
        state_next   = state;
        start_data_c = 1'b0;
        sf_done_c    = 1'b0;
        lose_lock_c  = 1'b0;
        if (tos_ce) begin
            case (state)
                HUNT: begin
                    if (pre_match_c) begin
                        state_next   = DATA;
                        start_data_c = 1'b1;
                    end
                end
                DATA: begin
                    // First cell of every bit must toggle against the previous cell
                    if (!cell_cnt[0] && (tos_data == prev_cell)) begin
                        state_next  = HUNT;
                        lose_lock_c = 1'b1;
                    end else if (cell_cnt == CNT_W'(DATA_CELLS - 1)) begin
                        state_next = PRE;
                        sf_done_c  = 1'b1;
                    end
                end
                PRE: begin
                    if (pre_cnt == PRE_CNT_W'(WIN_WIDTH - 1)) begin
                        if (pre_match_c) begin
                            state_next   = DATA;
                            start_data_c = 1'b1;
                        end else begin
                            state_next  = HUNT;
                            lose_lock_c = 1'b1;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_win     <= '0;
            cell_cnt     <= '0;
            pre_cnt      <= '0;
            prev_cell    <= 1'b0;
            pre_type     <= PT_B;
            sf           <= '0;
            sample_valid <= 1'b0;
            sample       <= '0;
            chan         <= 1'b0;
            block_start  <= 1'b0;
            v_bit        <= 1'b0;
            u_bit        <= 1'b0;
            c_bit        <= 1'b0;
            parity_err   <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (tos_ce) begin
                cell_win  <= win_next_c;
                prev_cell <= tos_data;
                if (state == DATA) begin
                    cell_cnt <= cell_cnt + CNT_W'(1);
                    if (cell_cnt[0]) sf <= sf_next_c;
                end
                if (state == PRE) pre_cnt <= pre_cnt + PRE_CNT_W'(1);
                if (start_data_c) begin
                    cell_cnt <= '0;
                    pre_type <= pre_type_c;
                end
                if (sf_done_c) begin
                    sample      <= sf_next_c[AUDIO_MSB-AUX_LSB:0];
                    chan        <= (pre_type == PT_W);
                    block_start <= (pre_type == PT_B);
                    v_bit       <= sf_next_c[BIT_V-AUX_LSB];
                    u_bit       <= sf_next_c[BIT_U-AUX_LSB];
                    c_bit       <= sf_next_c[BIT_C-AUX_LSB];
                    parity_err  <= parity_c;
                    locked      <= 1'b1;
                    pre_cnt     <= '0;
`ifdef SPDIF_PARITY_DROP_EN
                    sample_valid <= ~parity_c;
`else
                    sample_valid <= 1'b1;
`endif
                end
                if (lose_lock_c) locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spdif_subframe_decoder.sv
// Directed bench for spdif_subframe_decoder: biphase-mark encoded subframes
// with hand-chosen samples, checked against hand-computed expectations.
module tb_spdif_subframe_decoder;
    import spdif_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        tos_ce;
    logic        tos_data;
    logic        sample_valid;
    logic [23:0] sample;
    logic        chan, block_start, v_bit, u_bit, c_bit, parity_err, locked;

    int   n_tests  = 0;
    int   n_failed = 0;
    int   pulse_cnt = 0;
    int   base;
    int   gap = 1;
    logic level = 1'b0;

    spdif_subframe_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .tos_ce       (tos_ce),
        .tos_data     (tos_data),
        .sample_valid (sample_valid),
        .sample       (sample),
        .chan         (chan),
        .block_start  (block_start),
        .v_bit        (v_bit),
        .u_bit        (u_bit),
        .c_bit        (c_bit),
        .parity_err   (parity_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sample_valid === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_cell(input logic d);
        tos_ce = 1'b1; tos_data = d;
        @(posedge clk); #1;
        tos_ce = 1'b0; level = d;
        repeat (gap - 1) begin @(posedge clk); #1; end
    endtask

    task automatic send_bit(input logic b);
        send_cell(~level);
        send_cell(b ? ~level : level);
    endtask

    task automatic send_pre(input logic [7:0] p);
        for (int i = 7; i >= 0; i--) send_cell(p[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    // Full subframe; last cell handled inline to check pulse latency and width
    task automatic send_subframe(input logic [7:0] p, input logic [23:0] smp,
                                 input logic v, input logic u, input logic c,
                                 input logic flip, input logic exp_valid);
        logic [27:0] bits;
        logic        par;
        par  = (^{c, u, v, smp}) ^ flip;
        bits = {par, c, u, v, smp};
        send_pre(p);
        for (int i = 0; i < 27; i++) send_bit(bits[i]);
        send_cell(~level);
        tos_ce = 1'b1; tos_data = bits[27] ? ~level : level;
        @(posedge clk); #1;
        tos_ce = 1'b0; level = tos_data;
        check("valid_latency", 32'(sample_valid), 32'(exp_valid));
        @(posedge clk); #1;
        check("valid_width", 32'(sample_valid), 32'd0);
        repeat ((gap > 2) ? gap - 2 : 0) begin @(posedge clk); #1; end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},  32'(sample_valid), 32'd0);
        check({tag, "_sample"}, 32'(sample),       32'd0);
        check({tag, "_chan"},   32'(chan),         32'd0);
        check({tag, "_bstart"}, 32'(block_start),  32'd0);
        check({tag, "_vuc"},    32'({v_bit, u_bit, c_bit}), 32'd0);
        check({tag, "_perr"},   32'(parity_err),   32'd0);
        check({tag, "_locked"}, 32'(locked),       32'd0);
        check({tag, "_state"},  32'(dut.state),    32'(HUNT));
    endtask

    initial begin
        reset = 1'b1; tos_ce = 1'b0; tos_data = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_zero("rst");

        // Full B subframe from HUNT
        idle(4);
        base = pulse_cnt;
        send_subframe(PRE_B, 24'hA5F00F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t1_pulses", 32'(pulse_cnt - base), 32'd1);
        check("t1_sample", 32'(sample), 32'h00A5F00F);
        check("t1_bstart", 32'(block_start), 32'd1);
        check("t1_chan",   32'(chan), 32'd0);
        check("t1_vuc",    32'({v_bit, u_bit, c_bit}), 32'b010);
        check("t1_perr",   32'(parity_err), 32'd0);
        check("t1_locked", 32'(locked), 32'd1);

        // Inverted W preamble, streamed through PRE
        base = pulse_cnt;
        send_subframe(8'b0001_1011, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_pulses", 32'(pulse_cnt - base), 32'd1);
        check("t2_chan",   32'(chan), 32'd1);
        check("t2_sample", 32'(sample), 32'h00000001);
        check("t2_bstart", 32'(block_start), 32'd0);
        check("t2_locked", 32'(locked), 32'd1);

        // Missing boundary transition at subframe bit 10
        base = pulse_cnt;
        send_pre(PRE_B);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        send_cell(level);
        check("t3_unlock", 32'(locked), 32'd0);
        idle(4);
        check("t3_no_pulse", 32'(pulse_cnt - base), 32'd0);
        send_subframe(PRE_M, 24'h123456, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_pulses", 32'(pulse_cnt - base), 32'd1);
        check("t3_sample", 32'(sample), 32'h00123456);
        check("t3_vuc",    32'({v_bit, u_bit, c_bit}), 32'b101);
        check("t3_bstart", 32'(block_start), 32'd0);
        check("t3_chan",   32'(chan), 32'd0);
        check("t3_relock", 32'(locked), 32'd1);

        // Flipped parity bit
        base = pulse_cnt;
`ifdef SPDIF_PARITY_DROP_EN
        send_subframe(PRE_B, 24'h0F0F0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_pulses", 32'(pulse_cnt - base), 32'd0);
`else
        send_subframe(PRE_B, 24'h0F0F0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t4_pulses", 32'(pulse_cnt - base), 32'd1);
        check("t4_sample", 32'(sample), 32'h000F0F0F);
`endif
        check("t4_perr",   32'(parity_err), 32'd1);
        check("t4_locked", 32'(locked), 32'd1);

        // Throttled strobe, M then partial W, reset mid-subframe
        gap = 16;
        idle(4);
        base = pulse_cnt;
        send_subframe(PRE_M, 24'h654321, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_sample", 32'(sample), 32'h00654321);
        check("t5_locked", 32'(locked), 32'd1);
        send_pre(PRE_W);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero("t5_rst");
        repeat (40) @(posedge clk);
        #1;
        check("t5_pulses", 32'(pulse_cnt - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
